deserializer_word_aligner: RTL and testbench
============================================

Name: deserializer_word_aligner

Overview:
Serial-to-parallel receiver, the receive-side counterpart of the example-design serializer path. It samples one bit per clk_in cycle and assembles WIDTH-bit words, MSB first. Word-boundary alignment is either manual (bitslip) or automatic (hunt for ALIGN_PATTERN). It also re-times a channel-bond sync flag onto word boundaries.

Parameters:
WIDTH, 4, word width in bits; legal range 3..10.
AUTO_ALIGN, 0, 1 = hardware pattern hunt enabled; 0 = manual bitslip only.
ALIGN_PATTERN, 4'b1000 (WIDTH bits), training word searched for in HUNT.

Ports:
clk_in  input  1  single clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset.
data_in  input  1  serial data, sampled on every rising edge while enable=1.
enable  input  1  1 = sample and advance; 0 = all state frozen.
bitslip  input  1  manual slip request; rising-edge detected.
realign  input  1  one-cycle pulse: LOCKED->HUNT; ignored when AUTO_ALIGN=0.
channel_bond_sync_in  input  1  sync flag to be carried to the word boundary.
data_out  output  WIDTH  last completed word; first-received bit in data_out[WIDTH-1].
data_valid  output  1  one-cycle pulse when data_out updates.
aligned  output  1  1 in LOCKED state.
channel_bond_sync_out  output  1  channel_bond_sync_in captured at the last word boundary.

Behaviour:
- Reset (reset=0, async): shift register=0, bit counter=0, fill counter=0, data_out=0, data_valid=0, aligned=0, channel_bond_sync_out=0, bitslip edge register=0. State = HUNT if AUTO_ALIGN=1, otherwise LOCKED.
- AUTO_ALIGN=0: aligned=1 from the first edge after reset release.
- Sampling: on each edge with enable=1, data_in shifts into the LSB of the shift register. The candidate word is {shreg[WIDTH-2:0], data_in}.
- LOCKED, bit counter cnt 0..WIDTH-1:
  - When cnt==WIDTH-1 and no slip this cycle: data_out <= candidate word, data_valid=1 for that cycle, channel_bond_sync_out <= channel_bond_sync_in, cnt <= 0.
  - Otherwise cnt increments.
  - Latency: data_out and data_valid register on the same edge that samples the word's last bit. Steady-state period is WIDTH cycles.
- Bitslip (LOCKED only):
  - A rising edge of bitslip sampled with enable=1 holds cnt for that cycle. The bit still shifts in.
  - Effect: the word boundary moves one bit later; the affected word spans WIDTH+1 samples and only the last WIDTH are kept.
  - If the slip coincides with cnt==WIDTH-1, no word is emitted that cycle; the word emits on the next edge.
  - A held-high bitslip produces exactly one slip.
  - Bitslip is ignored in HUNT.
- HUNT (AUTO_ALIGN=1):
  - data_valid=0. The fill counter counts samples and saturates at WIDTH.
  - Once fill has reached WIDTH-1 and the candidate word == ALIGN_PATTERN: data_out <= ALIGN_PATTERN, data_valid=1, cnt <= 0, state -> LOCKED, aligned=1 on the same edge.
- LOCKED + realign=1: state -> HUNT, fill counter <= 0, aligned=0, data_valid=0. A word completing on that same edge is discarded.
- enable=0: nothing changes except data_valid, which is forced to 0. Reset still acts.
- Reset mid-word: the partial word is dropped; no data_valid is issued.
- data_out holds its value between valid pulses.

Test Plan:
- WIDTH=4, AUTO_ALIGN=0, enable=1 from reset release, bits 1,0,1,1,0,1,1,0 -> data_valid on the 4th and 8th sampling edges; data_out=4'b1011 then 4'b0110; aligned=1.
- Repeating stream 1,0,0,0 aligned to boundary -> data_out=1000 each word. One bitslip pulse -> subsequent words 0001; three more single slips (spaced ≥8 cycles) -> 0010, 0100, 1000; the word containing each slip arrives 5 cycles after the previous one.
- AUTO_ALIGN=1, stream 0,0,1,0 repeating from reset release -> first data_valid on the 6th sampling edge with data_out=1000, aligned=1, then 1000 every 4 cycles. realign pulse -> aligned=0, no data_valid until the next match.
- enable deasserted for 3 cycles after 2 bits of a word -> no data_valid during stall; word completes 2 enabled cycles after re-enable with the correct bits.
- reset pulsed low mid-word (after 2 bits) -> all outputs 0 immediately; next word counted fresh from release.
- channel_bond_sync_in=1 at a boundary edge, 0 at the next -> channel_bond_sync_out=1 for first word, 0 for the following word, unchanged between boundaries.

Source files
------------

// File: rtl/deserializer_word_aligner.sv
// rtl/deserializer_word_aligner.sv - serial-to-parallel receiver with bitslip / pattern word alignment
//
// Purpose:
//   Shifts in one bit per enabled clk_in edge (MSB first) and emits WIDTH-bit
//   words. The word boundary is moved either manually (bitslip rising edge,
//   LOCKED only) or found automatically by hunting for ALIGN_PATTERN
//   (AUTO_ALIGN=1). channel_bond_sync_in is re-timed onto word boundaries.
//
// Ports:
//   clk_in                 in   clock, rising edge
//   reset                  in   asynchronous active-low reset
//   data_in                in   serial data bit
//   enable                 in   1 = sample and advance, 0 = freeze (data_valid forced 0)
//   bitslip                in   manual slip request, rising-edge detected
//   realign                in   LOCKED -> HUNT pulse (AUTO_ALIGN=1 only)
//   channel_bond_sync_in   in   sync flag captured at each word boundary
//   data_out               out  last completed word, first bit in MSB
//   data_valid             out  one-cycle pulse when data_out updates
//   aligned                out  1 while LOCKED
//   channel_bond_sync_out  out  sync flag captured at the last word boundary

module deserializer_word_aligner #(
  parameter int unsigned       WIDTH         = 4,
  parameter bit                AUTO_ALIGN    = 1'b0,
  parameter logic [WIDTH-1:0]  ALIGN_PATTERN = {1'b1, {(WIDTH-1){1'b0}}}
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             data_in,
  input  logic             enable,
  input  logic             bitslip,
  input  logic             realign,
  input  logic             channel_bond_sync_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             aligned,
  output logic             channel_bond_sync_out
);

  // Wide enough for both the bit counter (0..WIDTH-1) and the saturating fill counter (0..WIDTH).
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e           state_q;
  logic [WIDTH-2:0] shreg_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    fill_q;
  logic [WIDTH-1:0] data_out_q;
  logic             data_valid_q;
  logic             aligned_q;
  logic             cbs_q;
  logic             bitslip_q;

  logic [WIDTH-1:0] cand_d;
  logic             slip_d;

  // The word that would be complete if this edge were a boundary.
  assign cand_d = {shreg_q, data_in};
  assign slip_d = bitslip & ~bitslip_q;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q      <= AUTO_ALIGN ? ST_HUNT : ST_LOCKED;
      shreg_q      <= '0;
      cnt_q        <= '0;
      fill_q       <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      aligned_q    <= 1'b0;
      cbs_q        <= 1'b0;
      bitslip_q    <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      // Manual-only builds are locked by construction; report it from the first edge.
      if (!AUTO_ALIGN) begin
        aligned_q <= 1'b1;
      end
      if (enable) begin
        shreg_q   <= cand_d[WIDTH-2:0];
        bitslip_q <= bitslip;
        case (state_q)
          ST_HUNT: begin
            if (fill_q != CW'(WIDTH)) begin
              fill_q <= fill_q + 1'b1;
            end
            // fill_q counts earlier samples; with this bit the candidate holds WIDTH real samples.
            if ((fill_q >= CW'(WIDTH - 1)) && (cand_d == ALIGN_PATTERN)) begin
              data_out_q   <= ALIGN_PATTERN;
              data_valid_q <= 1'b1;
              cnt_q        <= '0;
              aligned_q    <= 1'b1;
              state_q      <= ST_LOCKED;
            end
          end
          ST_LOCKED: begin
            if (AUTO_ALIGN && realign) begin
              // Any word finishing on this edge is dropped.
              state_q   <= ST_HUNT;
              fill_q    <= '0;
              cnt_q     <= '0;
              aligned_q <= 1'b0;
            end else if (!slip_d) begin
              if (cnt_q == CW'(WIDTH - 1)) begin
                data_out_q   <= cand_d;
                data_valid_q <= 1'b1;
                cbs_q        <= channel_bond_sync_in;
                cnt_q        <= '0;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
            // A slip holds cnt_q for one sample, pushing the boundary one bit later.
          end
          default: begin
            state_q <= AUTO_ALIGN ? ST_HUNT : ST_LOCKED;
          end
        endcase
      end
    end
  end

  assign data_out              = data_out_q;
  assign data_valid            = data_valid_q;
  assign aligned               = aligned_q;
  assign channel_bond_sync_out = cbs_q;

endmodule

// File: tb/tb_deserializer_word_aligner.sv
// tb/tb_deserializer_word_aligner.sv - directed table-driven bench for deserializer_word_aligner

module tb_deserializer_word_aligner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0_n, rst1_n;
  logic       din, en, bs, ra, cbs;
  logic [3:0] do0, do1;
  logic       dv0, dv1, al0, al1, co0, co1;

  int total = 0;
  int bad   = 0;

  deserializer_word_aligner #(.WIDTH(4), .AUTO_ALIGN(1'b0)) u_man (
    .clk_in(clk), .reset(rst0_n), .data_in(din), .enable(en), .bitslip(bs),
    .realign(ra), .channel_bond_sync_in(cbs), .data_out(do0), .data_valid(dv0),
    .aligned(al0), .channel_bond_sync_out(co0)
  );

  deserializer_word_aligner #(.WIDTH(4), .AUTO_ALIGN(1'b1)) u_auto (
    .clk_in(clk), .reset(rst1_n), .data_in(din), .enable(en), .bitslip(bs),
    .realign(ra), .channel_bond_sync_in(cbs), .data_out(do1), .data_valid(dv1),
    .aligned(al1), .channel_bond_sync_out(co1)
  );

  // ins = {data_in, enable, bitslip, realign, cbs_in}
  // exp = {data_valid, data_out[3:0], aligned, cbs_out}
  typedef struct {
    logic [4:0] ins;
    logic [6:0] exp;
  } vec_t;

  vec_t man_v[$];
  vec_t auto_v[$];

  function automatic vec_t mk(input logic [4:0] ins, input logic [6:0] exp);
    vec_t v;
    v.ins = ins;
    v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input bit sel, input logic [6:0] e);
    chk({tag, " dv"},  {3'b000, (sel ? dv1 : dv0)}, {3'b000, e[6]});
    chk({tag, " do"},  (sel ? do1 : do0),           e[5:2]);
    chk({tag, " al"},  {3'b000, (sel ? al1 : al0)}, {3'b000, e[1]});
    chk({tag, " cbo"}, {3'b000, (sel ? co1 : co0)}, {3'b000, e[0]});
  endtask

  task automatic run_vec(input vec_t v, input bit sel, input string tag);
    {din, en, bs, ra, cbs} = v.ins;
    @(posedge clk);
    #1;
    chk_outs(tag, sel, v.exp);
  endtask

  initial begin
    // Manual mode: basic words + cbs, four slips (one on cnt==3), stall, ignored realign.
    man_v.push_back(mk(5'b11000, 7'b0_0000_1_0));
    man_v.push_back(mk(5'b01000, 7'b0_0000_1_0));
    man_v.push_back(mk(5'b11000, 7'b0_0000_1_0));
    man_v.push_back(mk(5'b11001, 7'b1_1011_1_1));
    man_v.push_back(mk(5'b01001, 7'b0_1011_1_1));
    man_v.push_back(mk(5'b11001, 7'b0_1011_1_1));
    man_v.push_back(mk(5'b11000, 7'b0_1011_1_1));
    man_v.push_back(mk(5'b01000, 7'b1_0110_1_0));
    man_v.push_back(mk(5'b11000, 7'b0_0110_1_0));   // 9
    man_v.push_back(mk(5'b01000, 7'b0_0110_1_0));
    man_v.push_back(mk(5'b01000, 7'b0_0110_1_0));
    man_v.push_back(mk(5'b01000, 7'b1_1000_1_0));
    man_v.push_back(mk(5'b11000, 7'b0_1000_1_0));
    man_v.push_back(mk(5'b01000, 7'b0_1000_1_0));
    man_v.push_back(mk(5'b01000, 7'b0_1000_1_0));
    man_v.push_back(mk(5'b01000, 7'b1_1000_1_0));   // 16
    man_v.push_back(mk(5'b11100, 7'b0_1000_1_0));   // 17 slip, held high 3 cycles
    man_v.push_back(mk(5'b01100, 7'b0_1000_1_0));
    man_v.push_back(mk(5'b01100, 7'b0_1000_1_0));
    man_v.push_back(mk(5'b01000, 7'b0_1000_1_0));
    man_v.push_back(mk(5'b11000, 7'b1_0001_1_0));   // 21
    man_v.push_back(mk(5'b01000, 7'b0_0001_1_0));
    man_v.push_back(mk(5'b01000, 7'b0_0001_1_0));
    man_v.push_back(mk(5'b01000, 7'b0_0001_1_0));
    man_v.push_back(mk(5'b11000, 7'b1_0001_1_0));   // 25
    man_v.push_back(mk(5'b01100, 7'b0_0001_1_0));   // 26 slip
    man_v.push_back(mk(5'b01000, 7'b0_0001_1_0));
    man_v.push_back(mk(5'b01000, 7'b0_0001_1_0));
    man_v.push_back(mk(5'b11000, 7'b0_0001_1_0));
    man_v.push_back(mk(5'b01000, 7'b1_0010_1_0));   // 30
    man_v.push_back(mk(5'b01000, 7'b0_0010_1_0));
    man_v.push_back(mk(5'b01000, 7'b0_0010_1_0));
    man_v.push_back(mk(5'b11000, 7'b0_0010_1_0));
    man_v.push_back(mk(5'b01000, 7'b1_0010_1_0));   // 34
    man_v.push_back(mk(5'b01000, 7'b0_0010_1_0));
    man_v.push_back(mk(5'b01000, 7'b0_0010_1_0));
    man_v.push_back(mk(5'b11000, 7'b0_0010_1_0));
    man_v.push_back(mk(5'b01100, 7'b0_0010_1_0));   // 38 slip on boundary: no word
    man_v.push_back(mk(5'b01000, 7'b1_0100_1_0));   // 39
    man_v.push_back(mk(5'b01000, 7'b0_0100_1_0));
    man_v.push_back(mk(5'b11000, 7'b0_0100_1_0));
    man_v.push_back(mk(5'b01000, 7'b0_0100_1_0));
    man_v.push_back(mk(5'b01000, 7'b1_0100_1_0));   // 43
    man_v.push_back(mk(5'b01000, 7'b0_0100_1_0));
    man_v.push_back(mk(5'b11000, 7'b0_0100_1_0));
    man_v.push_back(mk(5'b01000, 7'b0_0100_1_0));
    man_v.push_back(mk(5'b01000, 7'b1_0100_1_0));   // 47
    man_v.push_back(mk(5'b01100, 7'b0_0100_1_0));   // 48 slip
    man_v.push_back(mk(5'b11000, 7'b0_0100_1_0));
    man_v.push_back(mk(5'b01000, 7'b0_0100_1_0));
    man_v.push_back(mk(5'b01000, 7'b0_0100_1_0));
    man_v.push_back(mk(5'b01000, 7'b1_1000_1_0));   // 52
    man_v.push_back(mk(5'b11000, 7'b0_1000_1_0));
    man_v.push_back(mk(5'b11010, 7'b0_1000_1_0));   // realign ignored in manual mode
    man_v.push_back(mk(5'b00001, 7'b0_1000_1_0));   // 55..57 stall
    man_v.push_back(mk(5'b00101, 7'b0_1000_1_0));
    man_v.push_back(mk(5'b00001, 7'b0_1000_1_0));
    man_v.push_back(mk(5'b01000, 7'b0_1000_1_0));
    man_v.push_back(mk(5'b11001, 7'b1_1101_1_1));   // 59
    man_v.push_back(mk(5'b11000, 7'b0_1101_1_1));
    man_v.push_back(mk(5'b11000, 7'b0_1101_1_1));   // 61, two bits into a word

    // Auto mode: hunt, lock, realign on a boundary, realign then fill gating.
    auto_v.push_back(mk(5'b01000, 7'b0_0000_0_0));
    auto_v.push_back(mk(5'b01000, 7'b0_0000_0_0));
    auto_v.push_back(mk(5'b11000, 7'b0_0000_0_0));
    auto_v.push_back(mk(5'b01000, 7'b0_0000_0_0));
    auto_v.push_back(mk(5'b01000, 7'b0_0000_0_0));
    auto_v.push_back(mk(5'b01000, 7'b1_1000_1_0));  // 6
    auto_v.push_back(mk(5'b11000, 7'b0_1000_1_0));
    auto_v.push_back(mk(5'b01000, 7'b0_1000_1_0));
    auto_v.push_back(mk(5'b01000, 7'b0_1000_1_0));
    auto_v.push_back(mk(5'b01000, 7'b1_1000_1_0));  // 10
    auto_v.push_back(mk(5'b11000, 7'b0_1000_1_0));
    auto_v.push_back(mk(5'b01000, 7'b0_1000_1_0));
    auto_v.push_back(mk(5'b01000, 7'b0_1000_1_0));
    auto_v.push_back(mk(5'b01010, 7'b0_1000_0_0));  // 14 realign discards word
    auto_v.push_back(mk(5'b11000, 7'b0_1000_0_0));
    auto_v.push_back(mk(5'b01000, 7'b0_1000_0_0));
    auto_v.push_back(mk(5'b01000, 7'b0_1000_0_0));
    auto_v.push_back(mk(5'b01000, 7'b1_1000_1_0));  // 18
    auto_v.push_back(mk(5'b11010, 7'b0_1000_0_0));  // 19 realign
    auto_v.push_back(mk(5'b01000, 7'b0_1000_0_0));
    auto_v.push_back(mk(5'b01100, 7'b0_1000_0_0));  // bitslip ignored in hunt
    auto_v.push_back(mk(5'b01000, 7'b0_1000_0_0));  // 22 pattern seen, fill too low
    auto_v.push_back(mk(5'b11000, 7'b0_1000_0_0));
    auto_v.push_back(mk(5'b01000, 7'b0_1000_0_0));
    auto_v.push_back(mk(5'b01000, 7'b0_1000_0_0));
    auto_v.push_back(mk(5'b01000, 7'b1_1000_1_0));  // 26
    auto_v.push_back(mk(5'b11000, 7'b0_1000_1_0));
    auto_v.push_back(mk(5'b01000, 7'b0_1000_1_0));
    auto_v.push_back(mk(5'b01000, 7'b0_1000_1_0));
    auto_v.push_back(mk(5'b01000, 7'b1_1000_1_0));  // 30

    rst0_n = 1'b0;
    rst1_n = 1'b0;
    {din, en, bs, ra, cbs} = 5'b00000;
    #12;
    chk_outs("rst_man", 1'b0, 7'b0_0000_0_0);
    chk_outs("rst_auto", 1'b1, 7'b0_0000_0_0);
    @(posedge clk);
    #1;
    rst0_n = 1'b1;

    for (int i = 0; i < man_v.size(); i++) begin
      run_vec(man_v[i], 1'b0, $sformatf("man%0d", i + 1));
    end

    // Asynchronous reset mid-word: outputs clear immediately, partial word dropped.
    rst0_n = 1'b0;
    #1;
    chk_outs("midrst_async", 1'b0, 7'b0_0000_0_0);
    @(posedge clk);
    #1;
    chk_outs("midrst_held", 1'b0, 7'b0_0000_0_0);
    rst0_n = 1'b1;
    run_vec(mk(5'b01000, 7'b0_0000_1_0), 1'b0, "post_rst1");
    run_vec(mk(5'b11000, 7'b0_0000_1_0), 1'b0, "post_rst2");
    run_vec(mk(5'b11000, 7'b0_0000_1_0), 1'b0, "post_rst3");
    run_vec(mk(5'b11000, 7'b1_0111_1_0), 1'b0, "post_rst4");

    rst1_n = 1'b1;
    for (int i = 0; i < auto_v.size(); i++) begin
      run_vec(auto_v[i], 1'b1, $sformatf("auto%0d", i + 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
